// File: rtl/clr_sched.sv
// clr_sched: timed/periodic clear-pulse scheduler with sw req/ack for the m01 stage.
// Define CLR_SCHED_CNT_EN to add the saturating clr_cnt_o pulse counter.
module clr_sched #(
  parameter int W  = 16,
  parameter int PW = 1,
  parameter int CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          mode_i,
  input  logic [W-1:0]  gap_i,
  input  logic          sw_req_i,
  output logic          sw_ack_o,
  output logic          clr_o,
`ifdef CLR_SCHED_CNT_EN
  output logic [CW-1:0] clr_cnt_o,
`endif
  output logic          busy_o
);

  localparam int PWW = (PW > 1) ? $clog2(PW) : 1;
  localparam logic [PWW-1:0] PW_LAST = PWW'(PW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_PULSE,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  state_t         ret_q, ret_d;
  state_t         nat;
  logic [W-1:0]   timer_q, timer_d;
  logic [PWW-1:0] pw_q, pw_d;
  logic           armed_q, armed_d;
  logic           mode_q, mode_d;
  logic           swp_q, swp_d;
  logic           ack_q, ack_d;
  logic           reload, pexit, accept, entry;

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    timer_d = timer_q;
    pw_d    = pw_q;
    mode_d  = mode_q;
    swp_d   = swp_q;
    ack_d   = 1'b0;
    armed_d = sw_req_i ? armed_q : 1'b1;
    nat     = state_q;
    reload  = 1'b0;
    pexit   = 1'b0;
    unique case (state_q)
      S_IDLE: if (en_i) reload = 1'b1;
      S_WAIT: begin
        if (!en_i) nat = S_IDLE;
        else if (timer_q == '0) nat = S_PULSE;
        else timer_d = timer_q - W'(1);
      end
      S_PULSE: begin
        if (pw_q != PW_LAST) begin
          pw_d = pw_q + PWW'(1);
        end else begin
          pexit = 1'b1;
          if (!en_i) nat = S_IDLE;
          else if (swp_q) begin
            if (ret_q == S_WAIT) reload = 1'b1;
            else nat = ret_q;
          end
          else if (mode_q) reload = 1'b1;
          else nat = S_DONE;
        end
      end
      S_DONE: if (!en_i) nat = S_IDLE;
      default: nat = S_IDLE;
    endcase
    if (reload) begin
      mode_d = mode_i;
      if (gap_i == '0) begin
        nat = S_PULSE;
      end else begin
        nat     = S_WAIT;
        timer_d = gap_i - W'(1);
      end
    end
    state_d = nat;
    accept  = sw_req_i && armed_q && (state_q != S_PULSE || pexit);
    // A request landing on a timed entry merges into that timed pulse.
    if (accept) begin
      state_d = S_PULSE;
      ack_d   = 1'b1;
      armed_d = 1'b0;
      swp_d   = (nat != S_PULSE);
      ret_d   = nat;
    end
    entry = (state_d == S_PULSE) && (state_q != S_PULSE || pexit);
    if (entry) pw_d = '0;
    if (entry && !accept) swp_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      timer_q <= '0;
      pw_q    <= '0;
      armed_q <= 1'b1;
      mode_q  <= 1'b0;
      swp_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      timer_q <= timer_d;
      pw_q    <= pw_d;
      armed_q <= armed_d;
      mode_q  <= mode_d;
      swp_q   <= swp_d;
      ack_q   <= ack_d;
    end
  end

  assign clr_o    = (state_q == S_PULSE);
  assign busy_o   = (state_q != S_IDLE);
  assign sw_ack_o = ack_q;

`ifdef CLR_SCHED_CNT_EN
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (entry && cnt_q != '1) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign clr_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_clr_sched.sv
// tb_clr_sched: directed bench; a monitor pops expected clr pulses
// (start cycle, width, ack count) from a scoreboard queue.
`timescale 1ns/1ps
module tb_clr_sched;
  localparam int W  = 16;
  localparam int PW = 3;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst, en, mode, sw_req;
  logic [W-1:0]  gap;
  logic          sw_ack, clr, busy;
`ifdef CLR_SCHED_CNT_EN
  logic [CW-1:0] clr_cnt;
`endif

  clr_sched #(.W(W), .PW(PW), .CW(CW)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (en),
    .mode_i   (mode),
    .gap_i    (gap),
    .sw_req_i (sw_req),
    .sw_ack_o (sw_ack),
    .clr_o    (clr),
`ifdef CLR_SCHED_CNT_EN
    .clr_cnt_o(clr_cnt),
`endif
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int start;
    int width;
    int acks;
  } ev_t;

  ev_t exp_q[$];
  int  pass_n = 0;
  int  tot_n  = 0;

  task automatic chk(input string nm, input int act, input int req);
    tot_n++;
    if (act == req) pass_n++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  nm, act, req, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input int s, input int w, input int a);
    ev_t e;
    e.start = s;
    e.width = w;
    e.acks  = a;
    exp_q.push_back(e);
  endtask

  task automatic chk_cnt(input string nm, input int req);
`ifdef CLR_SCHED_CNT_EN
    chk(nm, int'(clr_cnt), req);
`endif
  endtask

  // Monitor: gathers each clr-high run and checks it against the queue.
  bit in_p = 1'b0;
  int p_start, p_w, p_acks;
  always @(negedge clk) begin
    if (sw_ack === 1'b1) chk("ack_implies_clr", int'(clr), 1);
    if (clr === 1'b1) begin
      if (!in_p) begin
        in_p    = 1'b1;
        p_start = cyc;
        p_w     = 0;
        p_acks  = 0;
      end
      p_w++;
      if (sw_ack === 1'b1) p_acks++;
    end else if (in_p) begin
      in_p = 1'b0;
      if (exp_q.size() == 0) begin
        chk("pulse_unexpected_start", p_start, -1);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("pulse_start", p_start, e.start);
        chk("pulse_width", p_w, e.width);
        chk("pulse_acks", p_acks, e.acks);
      end
    end
  end

  task automatic do_reset();
    rst    = 1'b1;
    en     = 1'b0;
    sw_req = 1'b0;
    mode   = 1'b0;
    gap    = '0;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic end_test(input string nm);
    step(3);
    chk({nm, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    int m;
    do_reset();
    chk("rst_clr", int'(clr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack", int'(sw_ack), 0);
    chk_cnt("rst_cnt", 0);

    // one-shot, gap 5
    n = cyc;
    mode = 1'b0; gap = 5; en = 1'b1;
    expect_pulse(n + 6, 3, 0);
    step(20);
    chk("t1_done_busy", int'(busy), 1);
    chk("t1_done_clr", int'(clr), 0);
    chk_cnt("t1_cnt", 1);
    en = 1'b0;
    step(2);
    chk("t1_idle", int'(busy), 0);
    end_test("t1");

    // periodic gap 3, en dropped on 4th pulse
    do_reset();
    n = cyc;
    mode = 1'b1; gap = 3; en = 1'b1;
    for (int j = 0; j < 4; j++) expect_pulse(n + 4 + 6 * j, 3, 0);
    step(22);
    chk("t2_clr_at_drop", int'(clr), 1);
    en = 1'b0;
    step(3);
    chk("t2_idle", int'(busy), 0);
    chk_cnt("t2_cnt", 4);
    end_test("t2");

    // sw_req held in IDLE, then re-raised
    do_reset();
    n = cyc;
    sw_req = 1'b1;
    expect_pulse(n + 1, 3, 1);
    step(6);
    sw_req = 1'b0;
    step(2);
    sw_req = 1'b1;
    expect_pulse(n + 9, 3, 1);
    step(1);
    sw_req = 1'b0;
    step(5);
    chk("t3_idle", int'(busy), 0);
    chk_cnt("t3_cnt", 2);
    end_test("t3");

    // sw_req coincides with WAIT expiry, gap 4 periodic
    do_reset();
    n = cyc;
    mode = 1'b1; gap = 4; en = 1'b1;
    step(4);
    sw_req = 1'b1;
    expect_pulse(n + 5, 3, 1);
    step(1);
    sw_req = 1'b0;
    expect_pulse(n + 12, 3, 0);
    step(7);
    chk("t4_clr", int'(clr), 1);
    en = 1'b0;
    step(3);
    chk("t4_idle", int'(busy), 0);
    chk_cnt("t4_cnt", 2);
    end_test("t4");

    // sw pulse mid-WAIT returns with reload, one-shot
    do_reset();
    n = cyc;
    mode = 1'b0; gap = 6; en = 1'b1;
    step(2);
    sw_req = 1'b1;
    expect_pulse(n + 3, 3, 1);
    step(1);
    sw_req = 1'b0;
    expect_pulse(n + 12, 3, 0);
    step(17);
    chk("t4b_done_busy", int'(busy), 1);
    chk("t4b_done_clr", int'(clr), 0);
    en = 1'b0;
    step(2);
    chk("t4b_idle", int'(busy), 0);
    chk_cnt("t4b_cnt", 2);
    end_test("t4b");

    // en dropped mid-WAIT, then mid-PULSE
    do_reset();
    mode = 1'b1; gap = 5; en = 1'b1;
    step(2);
    chk("t5_wait_busy", int'(busy), 1);
    en = 1'b0;
    step(1);
    chk("t5_wait_abort", int'(busy), 0);
    step(8);
    end_test("t5a");
    m = cyc;
    gap = 2; en = 1'b1;
    expect_pulse(m + 3, 3, 0);
    step(3);
    chk("t5_pulse_clr", int'(clr), 1);
    en = 1'b0;
    step(2);
    chk("t5_pulse_busy", int'(busy), 1);
    step(1);
    chk("t5_pulse_idle", int'(busy), 0);
    step(6);
    end_test("t5b");

    // gap 0 periodic, sw at exit, saturation, reset mid-PULSE
    do_reset();
    n = cyc;
    mode = 1'b1; gap = 0; en = 1'b1;
    expect_pulse(n + 1, 30, 1);
    step(2);
    sw_req = 1'b1;
    step(1);
    chk("t6_no_ack_mid", int'(sw_ack), 0);
    step(1);
    chk("t6_ack_exit", int'(sw_ack), 1);
    sw_req = 1'b0;
    step(6);
    chk_cnt("t6_cnt4", 4);
    step(20);
    chk("t6_clr_high", int'(clr), 1);
    chk_cnt("t6_cnt_sat", 7);
    rst = 1'b1;
    step(1);
    chk("t6_rst_clr", int'(clr), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk_cnt("t6_rst_cnt", 0);
    rst = 1'b0;
    en = 1'b0;
    end_test("t6");

    step(2);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
